msrv32_trap_ctrl: RTL

- Machine-mode trap/return sequencer for the msrv32 core.
- Consumes the instruction decoder's exception flags (illegal instruction, misaligned load/store) plus the instruction-fetch misaligned flag and the interrupt lines.
- Produces `trap_taken`, which feeds back into the decoder, along with the PC-source select, pipeline flush and CSR update strobes.
- Sits between the decoder/PC unit and the machine CSR file.

---
 rtl/msrv32_trap_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/msrv32_trap_ctrl.sv
// msrv32_trap_ctrl
// Machine-mode trap and return sequencer for the msrv32 core.
// It watches the decoder exception flags, the fetch misalignment flag and the
// interrupt lines, and it steers the PC source, pipeline flush and CSR strobes
// through a short entry/return sequence.
//
// Ports:
//   clk_in, rst_in          clock; synchronous active-low reset
//   illegal_instr_in        decoder illegal-instruction flag
//   misaligned_instr_in     fetch target misaligned
//   misaligned_load_in      decoder misaligned-load flag
//   misaligned_store_in     decoder misaligned-store flag
//   opcode_6_to_2_in, funct3_in, funct7_in, rs2_addr_in
//                           instruction fields used to find ECALL/EBREAK/MRET
//   mie_in                  mstatus.MIE
//   irq_en_in, irq_pend_in  {MEIE,MTIE,MSIE} and {MEIP,MTIP,MSIP}
//   trap_taken_out          combinational: a trap is accepted this cycle
//   pc_src_out              00 boot, 01 mepc, 10 mtvec, 11 next-PC
//   flush_out               kill the instruction in the pipeline register
//   set_epc_out, set_cause_out
//                           mepc / mcause write strobes
//   cause_out, i_or_e_out   registered cause code and interrupt flag
//   mie_clear_out, mie_set_out
//                           mstatus.MIE clear on entry / restore on return
//   instret_inc_out         increment minstret
module msrv32_trap_ctrl #(
    parameter int CAUSE_W     = 4,
    parameter int ECALL_CAUSE = 11
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               illegal_instr_in,
    input  logic               misaligned_instr_in,
    input  logic               misaligned_load_in,
    input  logic               misaligned_store_in,
    input  logic [4:0]         opcode_6_to_2_in,
    input  logic [2:0]         funct3_in,
    input  logic [6:0]         funct7_in,
    input  logic [4:0]         rs2_addr_in,
    input  logic               mie_in,
    input  logic [2:0]         irq_en_in,
    input  logic [2:0]         irq_pend_in,
    output logic               trap_taken_out,
    output logic [1:0]         pc_src_out,
    output logic               flush_out,
    output logic               set_epc_out,
    output logic               set_cause_out,
    output logic [CAUSE_W-1:0] cause_out,
    output logic               i_or_e_out,
    output logic               mie_clear_out,
    output logic               mie_set_out,
    output logic               instret_inc_out
);

    typedef enum logic [1:0] {
        ST_RESET       = 2'd0,
        ST_OPERATING   = 2'd1,
        ST_TRAP_TAKEN  = 2'd2,
        ST_TRAP_RETURN = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CAUSE_W-1:0]   cause_q, cause_d;
    logic                 i_or_e_q, i_or_e_d;

    logic                 sys_f3_zero;
    logic                 is_ecall, is_ebreak, is_mret;
    logic [2:0]           irq_vec;
    logic                 irq, exc;
    logic [CAUSE_W-1:0]   trap_cause;
    logic                 trap_is_irq;

    // Decode of the SYSTEM instructions that matter here and the trap
    // conditions. irq_vec bit order is {MEI, MTI, MSI}.
    always_comb begin
        sys_f3_zero = (opcode_6_to_2_in == 5'b11100) && (funct3_in == 3'b000);
        is_ecall    = sys_f3_zero && (funct7_in == 7'b0000000) && (rs2_addr_in == 5'd0);
        is_ebreak   = sys_f3_zero && (funct7_in == 7'b0000000) && (rs2_addr_in == 5'd1);
        is_mret     = sys_f3_zero && (funct7_in == 7'b0011000) && (rs2_addr_in == 5'd2);
        irq_vec     = irq_en_in & irq_pend_in;
        irq         = mie_in & (|irq_vec);
        exc         = illegal_instr_in | misaligned_instr_in | misaligned_load_in |
                      misaligned_store_in | is_ecall | is_ebreak;
    end

    // Cause selection: interrupts first (MEI, MSI, MTI), then exceptions.
    // EBREAK outranks a misaligned fetch because both can flag on the same
    // instruction and the breakpoint is what the debugger expects to see.
    always_comb begin
        trap_cause  = '0;
        trap_is_irq = 1'b0;
        if (irq && irq_vec[2]) begin
            trap_cause  = CAUSE_W'(11);
            trap_is_irq = 1'b1;
        end else if (irq && irq_vec[0]) begin
            trap_cause  = CAUSE_W'(3);
            trap_is_irq = 1'b1;
        end else if (irq && irq_vec[1]) begin
            trap_cause  = CAUSE_W'(7);
            trap_is_irq = 1'b1;
        end else if (is_ebreak) begin
            trap_cause  = CAUSE_W'(3);
        end else if (misaligned_instr_in) begin
            trap_cause  = CAUSE_W'(0);
        end else if (illegal_instr_in) begin
            trap_cause  = CAUSE_W'(2);
        end else if (is_ecall) begin
            trap_cause  = CAUSE_W'(ECALL_CAUSE);
        end else if (misaligned_load_in) begin
            trap_cause  = CAUSE_W'(4);
        end else if (misaligned_store_in) begin
            trap_cause  = CAUSE_W'(6);
        end
    end

    // Next state and outputs. Only OPERATING can accept a trap; the entry and
    // return states are one-cycle redirects that ignore new requests. A trap
    // seen together with MRET wins and the MRET is dropped.
    always_comb begin
        state_d         = state_q;
        cause_d         = cause_q;
        i_or_e_d        = i_or_e_q;
        trap_taken_out  = 1'b0;
        pc_src_out      = 2'b11;
        flush_out       = 1'b0;
        set_epc_out     = 1'b0;
        set_cause_out   = 1'b0;
        mie_clear_out   = 1'b0;
        mie_set_out     = 1'b0;
        instret_inc_out = 1'b0;
        unique case (state_q)
            ST_RESET: begin
                pc_src_out = 2'b00;
                flush_out  = 1'b1;
                state_d    = ST_OPERATING;
            end
            ST_OPERATING: begin
                trap_taken_out = irq | exc;
                if (irq | exc) begin
                    state_d  = ST_TRAP_TAKEN;
                    cause_d  = trap_cause;
                    i_or_e_d = trap_is_irq;
                end else if (is_mret) begin
                    state_d = ST_TRAP_RETURN;
                end else begin
                    instret_inc_out = 1'b1;
                end
            end
            ST_TRAP_TAKEN: begin
                pc_src_out    = 2'b10;
                flush_out     = 1'b1;
                set_epc_out   = 1'b1;
                set_cause_out = 1'b1;
                mie_clear_out = 1'b1;
                state_d       = ST_OPERATING;
            end
            ST_TRAP_RETURN: begin
                pc_src_out  = 2'b01;
                flush_out   = 1'b1;
                mie_set_out = 1'b1;
                state_d     = ST_OPERATING;
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    // State, cause and interrupt flag registers; reset wins from any state.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q  <= ST_RESET;
            cause_q  <= '0;
            i_or_e_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            i_or_e_q <= i_or_e_d;
        end
    end

    assign cause_out  = cause_q;
    assign i_or_e_out = i_or_e_q;

endmodule
